iccm_byte_loader: RTL and testbench

//  Consumes the byte-serial program image (byte 0 = lowest address) produced by the

---
 rtl/iccm_byte_loader_pkg.sv | 13 +
 rtl/iccm_byte_loader_packer.sv | 38 +++
 rtl/iccm_byte_loader.sv | 127 ++++++++++++
 tb/tb_iccm_byte_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iccm_byte_loader_pkg.sv
// Shared types and constants for the ICCM byte loader: FSM states and word geometry.
package loader_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } loader_state_e;
endpackage

// File: rtl/iccm_byte_loader_packer.sv
// Little-endian byte-to-word packer: tracks the next lane and accumulates data and enables.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      load_i,
    input  logic [7:0]                byte_i,
    output logic [1:0]                idx_o,
    output logic [WORD_W-1:0]         wdata_o,
    output logic [BYTES_PER_WORD-1:0] be_o
);
    logic [1:0]                r_idx;
    logic [WORD_W-1:0]         r_wdata;
    logic [BYTES_PER_WORD-1:0] r_be;

    // Clear wins over load; the owning FSM never asserts both in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx   <= 2'd0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (clear_i) begin
            r_idx   <= 2'd0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (load_i) begin
            r_wdata[8*r_idx +: 8] <= byte_i;
            r_be[r_idx]           <= 1'b1;
            r_idx                 <= r_idx + 2'd1;
        end
    end

    assign idx_o   = r_idx;
    assign wdata_o = r_wdata;
    assign be_o    = r_be;
endmodule

// File: rtl/iccm_byte_loader.sv
// Packs a byte-serial program image into 32-bit words and writes them to the ICCM from word 0.
// Handshakes: a byte moves when byte_valid_i && byte_ready_o at posedge; a write completes when mem_req_o && mem_gnt_i at posedge.
module iccm_byte_loader
    import loader_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      byte_valid_i,
    output logic                      byte_ready_o,
    input  logic [7:0]                byte_data_i,
    input  logic                      byte_last_i,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic                      mem_we_o,
    output logic [MEM_AW-1:0]         mem_addr_o,
    output logic [WORD_W-1:0]         mem_wdata_o,
    output logic [BYTES_PER_WORD-1:0] mem_be_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overflow_o,
    output logic [MEM_AW:0]           word_cnt_o,
    output logic [2:0]                dbg_state_o
);
    localparam logic [MEM_AW-1:0] ADDR_MAX = '1;
    localparam logic [MEM_AW:0]   CNT_MAX  = {1'b1, {MEM_AW{1'b0}}};

    loader_state_e     r_state;
    loader_state_e     w_next;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_AW:0]   r_word_cnt;
    logic              r_last;
    logic              r_overflow;
    logic              w_start;
    logic              w_accept;
    logic              w_collect_ld;
    logic              w_gnt;
    logic [1:0]        w_idx;

    assign w_start      = (r_state == IDLE) && start_i;
    assign w_accept     = byte_valid_i && byte_ready_o;
    assign w_collect_ld = w_accept && (r_state == COLLECT);
    assign w_gnt        = (r_state == WRITE) && mem_gnt_i;

    byte_word_packer u_packer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (w_start || w_gnt),
        .load_i  (w_collect_ld),
        .byte_i  (byte_data_i),
        .idx_o   (w_idx),
        .wdata_o (mem_wdata_o),
        .be_o    (mem_be_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        byte_ready_o = 1'b0;
        mem_req_o    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_next = COLLECT;
            end
            COLLECT: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i && (w_idx == 2'd3 || byte_last_i)) w_next = WRITE;
            end
            WRITE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    if (r_last)                  w_next = DONE;
                    else if (r_addr == ADDR_MAX) w_next = DRAIN;
                    else                         w_next = COLLECT;
                end
            end
            DRAIN: begin
                byte_ready_o = 1'b1;
                if (byte_valid_i && byte_last_i) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Address stops at the top word; an image that still has bytes left spills into DRAIN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_collect_ld) r_last <= byte_last_i;
            if (w_gnt) begin
                r_last <= 1'b0;
                if (r_word_cnt != CNT_MAX) r_word_cnt <= r_word_cnt + 1'b1;
                if (!r_last) begin
                    if (r_addr == ADDR_MAX) r_overflow <= 1'b1;
                    else                    r_addr     <= r_addr + 1'b1;
                end
            end
        end
    end

    assign mem_we_o    = mem_req_o;
    assign mem_addr_o  = r_addr;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign overflow_o  = r_overflow;
    assign word_cnt_o  = r_word_cnt;
    assign dbg_state_o = r_state;
endmodule

// File: tb/tb_iccm_byte_loader.sv
// Bench for iccm_byte_loader: random images checked against a word-level model of the load.
module tb_iccm_byte_loader;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = AW + 36;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o;
    logic [7:0]    byte_data_i = 8'h00;
    logic          byte_last_i = 1'b0;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic          busy_o;
    logic          done_o;
    logic          overflow_o;
    logic [AW:0]   word_cnt_o;
    logic [2:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]    img[$];
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int            exp_cnt;
    logic          exp_ovf;
    int            done_cnt = 0;
    int            gnt_force = -1;

    iccm_byte_loader #(.MEM_AW(AW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .byte_data_i  (byte_data_i),
        .byte_last_i  (byte_last_i),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .word_cnt_o   (word_cnt_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the image cut into 4-byte little-endian words, truncated to memory depth.
    task automatic build_expected();
        int n, nw, wr;
        logic [31:0] d;
        logic [3:0]  be;
        n  = img.size();
        nw = (n + 3) / 4;
        wr = (nw > DEPTH) ? DEPTH : nw;
        exp_q.delete();
        for (int w = 0; w < wr; w++) begin
            d  = '0;
            be = '0;
            for (int b = 0; b < 4; b++) begin
                if (4 * w + b < n) begin
                    d[8*b +: 8] = img[4*w + b];
                    be[b]       = 1'b1;
                end
            end
            exp_q.push_back({w[AW-1:0], be, d});
        end
        exp_cnt = wr;
        exp_ovf = (nw > DEPTH);
    endtask

    // Memory responder: random or forced grant delay, checks the request holds still while waiting.
    initial begin : responder
        logic [EW-1:0] snap;
        bit            waiting;
        int            w_left;
        waiting = 0;
        w_left  = 0;
        snap    = '0;
        forever begin
            @(negedge clk_i);
            if (!mem_req_o) begin
                mem_gnt_i = 1'b0;
                waiting   = 0;
            end else begin
                if (!waiting) begin
                    waiting = 1;
                    w_left  = (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 2));
                    snap    = {mem_addr_o, mem_be_o, mem_wdata_o};
                    check_eq("we_with_req", mem_we_o, 1);
                end else begin
                    check_eq("req_stable", {mem_addr_o, mem_be_o, mem_wdata_o}, snap);
                    check_eq("ready_in_write", byte_ready_o, 0);
                end
                if (w_left == 0) begin
                    mem_gnt_i = 1'b1;
                    got_q.push_back(snap);
                    waiting   = 0;
                end else begin
                    mem_gnt_i = 1'b0;
                    w_left--;
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk_i);
            if (done_o) done_cnt++;
        end
    end

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check_eq("busy_after_start", busy_o, 1);
        check_eq("ovf_cleared", overflow_o, 0);
        check_eq("cnt_cleared", word_cnt_o, 0);
    endtask

    // Byte driver: gap_pct idle cycles; start_i re-pulsed while byte start_at is pending.
    task automatic send_image(input int gap_pct, input int start_at);
        int n, i, cyc;
        bit exp_req;
        n       = img.size();
        i       = 0;
        cyc     = 0;
        exp_req = 0;
        while (i < n && cyc < 2000) begin
            @(negedge clk_i);
            cyc++;
            if (exp_req) begin
                check_eq("req_latency", mem_req_o, 1);
                exp_req = 0;
            end
            start_i = (i == start_at);
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                byte_valid_i = 1'b0;
            end else begin
                byte_valid_i = 1'b1;
                byte_data_i  = img[i];
                byte_last_i  = (i == n - 1);
                if (byte_ready_o) begin
                    if (((i % 4) == 3 || i == n - 1) && (i / 4) < DEPTH) exp_req = 1;
                    i++;
                end
            end
        end
        @(negedge clk_i);
        if (exp_req) check_eq("req_latency", mem_req_o, 1);
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
        start_i      = 1'b0;
        if (i < n) check_eq("send_timeout", i, n);
    endtask

    task automatic run_image(input string name, input int gap_pct, input int start_at);
        int k, m;
        build_expected();
        got_q.delete();
        done_cnt = 0;
        pulse_start();
        send_image(gap_pct, start_at);
        k = 0;
        while (done_cnt == 0 && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (done_cnt == 0) check_eq({name, "_done_timeout"}, 0, 1);
        repeat (3) @(negedge clk_i);
        check_eq({name, "_done_pulses"}, done_cnt, 1);
        check_eq({name, "_busy_idle"}, busy_o, 0);
        check_eq({name, "_word_cnt"}, word_cnt_o, exp_cnt);
        check_eq({name, "_overflow"}, overflow_o, exp_ovf);
        check_eq({name, "_n_writes"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int j = 0; j < m; j++) check_eq({name, "_write"}, got_q[j], exp_q[j]);
    endtask

    initial begin : main
        int n;
        repeat (3) @(negedge clk_i);
        check_eq("reset_outputs",
                 {mem_req_o, mem_we_o, byte_ready_o, busy_o, done_o, overflow_o,
                  mem_be_o, mem_wdata_o, mem_addr_o, word_cnt_o, dbg_state_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_image("two_words", 0, -1);
        if (got_q.size() == 2) begin
            check_eq("two_words_w0", got_q[0], {2'd0, 4'hF, 32'h0000_0013});
            check_eq("two_words_w1", got_q[1], {2'd1, 4'hF, 32'h0010_0093});
        end

        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        run_image("partial", 0, -1);
        if (got_q.size() == 2) begin
            check_eq("partial_w1", got_q[1], {2'd1, 4'h3, 32'h0000_FFEE});
        end

        img = '{8'h5A};
        run_image("single_byte", 0, -1);

        gnt_force = 7;
        fill_random(8);
        run_image("gnt_stall", 0, -1);
        gnt_force = -1;

        fill_random(20);
        run_image("overflow", 0, -1);
        fill_random(16);
        run_image("exact_fill", 20, -1);
        fill_random(5);
        run_image("after_ovf", 0, -1);

        // reset asserted while a write request is waiting for grant
        gnt_force = 30;
        fill_random(4);
        got_q.delete();
        pulse_start();
        send_image(0, -1);
        @(negedge clk_i);
        check_eq("req_before_reset", mem_req_o, 1);
        rst_ni = 1'b0;
        #1;
        check_eq("req_drop_on_reset", mem_req_o, 0);
        check_eq("busy_on_reset", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        check_eq("no_write_on_reset", got_q.size(), 0);
        gnt_force = -1;
        fill_random(7);
        run_image("after_reset", 0, -1);

        fill_random(10);
        run_image("start_in_collect", 40, 2);

        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 22));
            fill_random(n);
            run_image("random", int'($urandom_range(0, 50)), int'($urandom_range(0, 30)) - 10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
